// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed scan of a frame snapshot onto a
// shared segment bus. Optional dead-time between digits: SEG_MUX_BLANKING_EN.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS       = 6,
    parameter int TICKS_PER_DIGIT  = 1000,
    parameter int BLANK_TICKS      = 16,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic [NUM_DIGITS-1:0][7:0]   in_7seg_display,
    output logic [7:0]                   out_segs,
    output logic [NUM_DIGITS-1:0]        out_anodes,
    output logic                         out_frame_start
);

    localparam int MAX_T = (TICKS_PER_DIGIT > BLANK_TICKS) ?
                           TICKS_PER_DIGIT : BLANK_TICKS;
    localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [7:0]            SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = ANODE_ACTIVE_LOW ? '1 : '0;
    localparam logic [CW-1:0]         ON_LAST  = CW'(TICKS_PER_DIGIT - 1);
    localparam logic [IW-1:0]         DIG_LAST = IW'(NUM_DIGITS - 1);

`ifdef SEG_MUX_BLANKING_EN
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
    typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;
    localparam state_t FIRST = BLANK;
`else
    typedef enum logic [1:0] {IDLE, ON} state_t;
    localparam state_t FIRST = ON;
`endif

    state_t                       state_q, state_d;
    logic [IW-1:0]                dig_idx_q, dig_idx_d;
    logic [CW-1:0]                tick_cnt_q, tick_cnt_d;
    logic [NUM_DIGITS-1:0][7:0]   snap_q, snap_d;
    logic [7:0]                   segs_d;
    logic [NUM_DIGITS-1:0]        anodes_d;
    logic                         frame_start_d;
    logic [7:0]                   cur_byte;
    logic [NUM_DIGITS-1:0]        one_hot;

    // Next-state sequencing: enable gating, phase timing, digit walk, reload.
    always_comb begin
        state_d       = state_q;
        dig_idx_d     = dig_idx_q;
        tick_cnt_d    = tick_cnt_q;
        snap_d        = snap_q;
        frame_start_d = 1'b0;
        if (!ena) begin
            state_d    = IDLE;
            dig_idx_d  = '0;
            tick_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d       = FIRST;
                    snap_d        = in_7seg_display;
                    dig_idx_d     = '0;
                    tick_cnt_d    = '0;
                    frame_start_d = 1'b1;
                end
`ifdef SEG_MUX_BLANKING_EN
                BLANK: begin
                    if (tick_cnt_q == BLANK_LAST) begin
                        state_d    = ON;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
`endif
                ON: begin
                    if (tick_cnt_q == ON_LAST) begin
                        state_d    = FIRST;
                        tick_cnt_d = '0;
                        if (dig_idx_q == DIG_LAST) begin
                            dig_idx_d     = '0;
                            snap_d        = in_7seg_display;
                            frame_start_d = 1'b1;
                        end else begin
                            dig_idx_d = dig_idx_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    dig_idx_d  = '0;
                    tick_cnt_d = '0;
                end
            endcase
        end
    end

    // Pin values derived from the next state so outputs change on the same edge.
    always_comb begin
        cur_byte = snap_d[dig_idx_d];
        one_hot  = NUM_DIGITS'(1) << dig_idx_d;
        segs_d   = SEG_OFF;
        anodes_d = AN_OFF;
        if (state_d == ON) begin
            segs_d   = SEG_ACTIVE_LOW ? ~cur_byte : cur_byte;
            anodes_d = ANODE_ACTIVE_LOW ? ~one_hot : one_hot;
        end
    end

    // State and registered outputs; reset is synchronous and overrides enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            dig_idx_q       <= '0;
            tick_cnt_q      <= '0;
            snap_q          <= '0;
            out_segs        <= SEG_OFF;
            out_anodes      <= AN_OFF;
            out_frame_start <= 1'b0;
        end else begin
            state_q         <= state_d;
            dig_idx_q       <= dig_idx_d;
            tick_cnt_q      <= tick_cnt_d;
            snap_q          <= snap_d;
            out_segs        <= segs_d;
            out_anodes      <= anodes_d;
            out_frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: cycle-tagged scoreboard for the scan driver,
// covering both polarities with two instances driven identically.
module tb_seven_seg_scan_driver;

    typedef struct {
        int         cyc;
        logic [5:0] an;
        logic [7:0] seg;
        logic       fs;
    } exp_t;

`ifdef SEG_MUX_BLANKING_EN
    localparam int P = 6;
    localparam int B = 2;
`else
    localparam int P = 4;
    localparam int B = 0;
`endif
    localparam int FRAME = 6 * P;

    logic            clk;
    logic            rst;
    logic            ena;
    logic [5:0][7:0] in_d;
    logic [7:0]      segs_a, segs_b;
    logic [5:0]      an_a, an_b;
    logic            fs_a, fs_b;

    exp_t q[$];
    exp_t mon_e;
    int   cyc;
    int   checks;
    int   failures;

    seven_seg_scan_driver #(
        .NUM_DIGITS(6), .TICKS_PER_DIGIT(4), .BLANK_TICKS(2),
        .SEG_ACTIVE_LOW(1'b1), .ANODE_ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .ena(ena),
        .in_7seg_display(in_d),
        .out_segs(segs_a), .out_anodes(an_a), .out_frame_start(fs_a)
    );

    seven_seg_scan_driver #(
        .NUM_DIGITS(6), .TICKS_PER_DIGIT(4), .BLANK_TICKS(2),
        .SEG_ACTIVE_LOW(1'b0), .ANODE_ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .ena(ena),
        .in_7seg_display(in_d),
        .out_segs(segs_b), .out_anodes(an_b), .out_frame_start(fs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t inactive();
        exp_t e;
        e.cyc = 0;
        e.an  = 6'h3F;
        e.seg = 8'hFF;
        e.fs  = 1'b0;
        return e;
    endfunction

    // Expected active-low pins n cycles after an enabling edge.
    function automatic exp_t model(int n, logic d0ff);
        exp_t       e;
        int         k;
        int         d;
        logic [7:0] byt;
        k     = n % P;
        d     = (n / P) % 6;
        e     = inactive();
        e.fs  = (n % FRAME) == 0;
        if (k >= B) begin
            byt = 8'(8'h10 + d);
            if (d == 0 && d0ff && n >= FRAME) byt = 8'hFF;
            e.seg = ~byt;
            e.an  = ~(6'b000001 << d);
        end
        return e;
    endfunction

    task automatic push(int c, exp_t e);
        exp_t t;
        t     = e;
        t.cyc = c;
        q.push_back(t);
    endtask

    task automatic chk(string nm, int c, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, act, exp);
        end
    endtask

    task automatic wait_cyc(int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare whichever expectation is tagged for this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_slot cyc=%0d got=none want=%0d", q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            mon_e = q.pop_front();
            chk("anodes_lo", cyc, {2'b00, an_a}, {2'b00, mon_e.an});
            chk("segs_lo", cyc, segs_a, mon_e.seg);
            chk("fs_lo", cyc, {7'd0, fs_a}, {7'd0, mon_e.fs});
            chk("anodes_hi", cyc, {2'b00, an_b}, {2'b00, ~mon_e.an});
            chk("segs_hi", cyc, segs_b, ~mon_e.seg);
            chk("fs_hi", cyc, {7'd0, fs_b}, {7'd0, mon_e.fs});
        end
    end

    initial begin
        int b;
        int b2;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        ena      = 1'b0;
        for (int i = 0; i < 6; i++) in_d[i] = 8'(8'h10 + i);

        wait_cyc(1);
        ena = 1'b1;
        for (int i = 2; i <= 4; i++) push(i, inactive());
        wait_cyc(4);
        rst = 1'b1;
        b   = 5;

        for (int n = 0; n <= FRAME + 5; n++) push(b + n, model(n, 1'b1));
        wait_cyc(b + 2);
        in_d[0] = 8'hFF;

        wait_cyc(b + FRAME + 5);
        ena     = 1'b0;
        in_d[0] = 8'h10;
        push(b + FRAME + 6, inactive());
        wait_cyc(b + FRAME + 6);
        ena = 1'b1;
        b2  = b + FRAME + 7;

        for (int n = 0; n <= 13; n++) push(b2 + n, model(n, 1'b0));
        for (int n = 14; n <= 20; n++) push(b2 + n, inactive());
        for (int n = 21; n <= 21 + P + 3; n++) push(b2 + n, model(n - 21, 1'b0));

        wait_cyc(b2 + 13);
        ena = 1'b0;
        wait_cyc(b2 + 20);
        ena = 1'b1;
        wait_cyc(b2 + 21 + P + 3);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout left=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Time-multiplexed scan driver for a physical common-segment 7-segment display. It consumes the per-digit segment bytes produced by `total_digit_drawer` (`out_7seg_display`) and takes a frame snapshot of them. It then lights one digit at a time through a shared segment bus and per-digit digit-select lines. It sits between the digit drawer and the board pins.

## Interface
Parameters:
- `NUM_DIGITS`, 6, number of physical digits; index 0 = rightmost.
- `TICKS_PER_DIGIT`, 1000, clk cycles each digit is lit; must be ≥1.
- `BLANK_TICKS`, 16, dead-time cycles before each digit; must be ≥1; used only when `SEG_MUX_BLANKING_EN` is defined.
- `SEG_ACTIVE_LOW`, 1, 1 = `out_segs` bit low lights the segment.
- `ANODE_ACTIVE_LOW`, 1, 1 = `out_anodes` bit low enables the digit.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `ena` in 1: scan enable.
- `in_7seg_display` in [NUM_DIGITS-1:0][7:0]: segment bytes, active-high, same bit encoding as the drawer output (bit 7 = decimal point).
- `out_segs` out 8: shared segment bus, polarity per `SEG_ACTIVE_LOW`.
- `out_anodes` out NUM_DIGITS: digit selects, one-hot active when lit, polarity per `ANODE_ACTIVE_LOW`.
- `out_frame_start` out 1: one-cycle pulse when digit 0 of a new frame begins.

## Operation
- State register with three states: IDLE, BLANK, ON. BLANK exists only with the macro.
- Internal registers:
  - `dig_idx` (0..NUM_DIGITS-1).
  - `tick_cnt`, width `$clog2` of max(TICKS_PER_DIGIT, BLANK_TICKS).
  - `snap`, a NUM_DIGITS×8 snapshot.
- IDLE: all outputs inactive. Inactive means segs all off and anodes all disabled, at the configured polarity.
- IDLE → first phase (BLANK if macro, else ON) on an edge with `rst`=1 and `ena`=1. At that edge:
  - `snap` ← `in_7seg_display`.
  - `dig_idx` = 0 and `tick_cnt` = 0.
  - `out_frame_start` ← 1.
- ON: `out_anodes` selects `dig_idx`; `out_segs` = `snap[dig_idx]` with polarity applied. Lasts TICKS_PER_DIGIT cycles.
- At the end of ON (`tick_cnt` == TICKS_PER_DIGIT-1):
  - If `dig_idx` == NUM_DIGITS-1, wrap to 0, reload `snap`, and pulse `out_frame_start`.
  - Otherwise increment `dig_idx`.
  - Next phase is BLANK (macro) or ON.
- BLANK: outputs inactive for BLANK_TICKS cycles, then ON for the same `dig_idx`.
- Input changes mid-frame have no effect until the next frame reload. This makes updates tear-free.
- `ena`=0 at any edge: go to IDLE, outputs inactive, counters cleared. Re-enable always restarts at digit 0 with a fresh snapshot and a frame pulse.
- `rst`=0 dominates `ena`. Mid-operation it forces IDLE state at that edge.
- Never more than one anode active. In BLANK and IDLE zero anodes are active.

## Timing
- All outputs registered. They are updated at the same edge as the state/`dig_idx` change they reflect, with no extra pipeline stage.
- Reset values: `out_segs` = inactive (8'hFF if SEG_ACTIVE_LOW, else 8'h00); `out_anodes` = inactive (all 1 if ANODE_ACTIVE_LOW, else all 0); `out_frame_start` = 0; `snap` = 0; state = IDLE.
- Let cycle 0 be the first cycle after the enabling edge.
- Frame period is NUM_DIGITS×TICKS_PER_DIGIT without the macro, and NUM_DIGITS×(BLANK_TICKS+TICKS_PER_DIGIT) with it.
- `out_frame_start` is high during cycle 0 of each frame only.
- With TICKS_PER_DIGIT=1 and no macro, a new digit is shown every cycle.

## Configuration
- `SEG_MUX_BLANKING_EN` defined: the BLANK state is compiled in. Every digit is preceded by BLANK_TICKS cycles with all anodes and segments inactive. This suppresses ghosting. `out_frame_start` pulses at the start of digit 0's BLANK phase.
- `SEG_MUX_BLANKING_EN` undefined: BLANK state and `BLANK_TICKS` logic are absent, and digits switch back-to-back.

## Test plan
Benches use NUM_DIGITS=6, TICKS_PER_DIGIT=4, BLANK_TICKS=2, both polarities active-low, and digit i byte = 8'h10+i, unless noted.
1. Reset: hold `rst`=0 for 3 cycles with `ena`=1 → `out_anodes`=6'b111111, `out_segs`=8'hFF, `out_frame_start`=0 throughout.
2. Scan order (no macro), after enabling edge:
   - Cycles 0–3: anodes 6'b111110, segs 8'hEF.
   - Cycles 4–7: anodes 6'b111101, segs 8'hEE.
   - Cycles 20–23: anodes 6'b011111, segs 8'hEA.
   - `out_frame_start` high at cycles 0 and 24 only.
3. Snapshot: set digit 0 byte to 8'hFF at cycle 2 → cycles 2–3 still show segs 8'hEF; cycle 24 shows segs 8'h00.
4. Enable drop: `ena`=0 at cycle 13 → from cycle 14 all outputs inactive. `ena`=1 at cycle 20 → next cycle restarts digit 0 with `out_frame_start`=1.
5. Blanking (`SEG_MUX_BLANKING_EN` defined):
   - Cycles 0–1: anodes 6'b111111, segs 8'hFF, frame_start=1 at cycle 0.
   - Cycles 2–5: digit 0.
   - Cycles 6–7: blank.
   - Next frame_start at cycle 36.
6. Polarity: SEG_ACTIVE_LOW=0, ANODE_ACTIVE_LOW=0 → reset outputs 8'h00 / 6'b000000; cycle 0 anodes 6'b000001, segs 8'h10.
